// File: rtl/pio_poll_pkg.sv
// Shared definitions for the PIO edge poller: PIO register map, poll FSM
// states and the event record carried through the event FIFO.
// PIO_POLL_TIMESTAMP_EN adds a 16-bit poll timestamp to each record.
package pio_poll_pkg;

    localparam logic [1:0]  PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0]  PIO_ADDR_EDGE = 2'd3;
    localparam logic [31:0] PIO_CLEAR_ALL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_EDGE,
        WAIT_EDGE,
        RD_DATA,
        WAIT_DATA,
        CLR,
        PUSH
    } poll_state_t;

    typedef struct packed {
`ifdef PIO_POLL_TIMESTAMP_EN
        logic [15:0] timestamp;
`endif
        logic [7:0]  mask;
        logic [7:0]  data;
    } evt_rec_t;

endpackage

// File: rtl/pio_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for event records.
// A push while full is accepted when a pop happens in the same cycle.
module pio_evt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage write port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pio_edge_poller.sv
// Avalon-MM master that polls an 8-bit edge-capturing PIO and queues
// {edge mask, input level} records for a valid/ready consumer.
// Define PIO_POLL_TIMESTAMP_EN to stamp each record with a 16-bit cycle count.
//
// state     | meaning
// IDLE      | counting the poll interval while enabled
// RD_EDGE   | read strobe to the edge-capture register
// WAIT_EDGE | sample edge mask; zero mask ends the poll
// RD_DATA   | read strobe to the data register
// WAIT_DATA | sample input level
// CLR       | write all ones to edge capture
// PUSH      | queue record, or count a drop when the FIFO is full
module pio_edge_poller
    import pio_poll_pkg::*;
#(
    parameter int unsigned POLL_INTERVAL = 1000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_mask,
    output logic [7:0]  evt_data,
`ifdef PIO_POLL_TIMESTAMP_EN
    output logic [15:0] evt_timestamp,
`endif
    output logic [7:0]  overflow_count,
    output logic        busy
);

    localparam logic [15:0] INTERVAL_LAST = 16'(POLL_INTERVAL - 1);

    poll_state_t state;
    poll_state_t state_nxt;
    logic [15:0] interval_cnt;
    logic [15:0] interval_nxt;
    logic [1:0]  addr_nxt;
    logic        cs_nxt;
    logic        write_n_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  mask_q;
    logic [7:0]  data_q;
    evt_rec_t    push_rec;
    evt_rec_t    head_rec;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        drop;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^avm_readdata[31:8];

    // Next state, interval count, and bus strobes for the state being entered
    always_comb begin
        state_nxt    = state;
        interval_nxt = interval_cnt;
        case (state)
            IDLE: begin
                if (!enable) begin
                    interval_nxt = '0;
                end else if (interval_cnt == INTERVAL_LAST) begin
                    interval_nxt = '0;
                    state_nxt    = RD_EDGE;
                end else begin
                    interval_nxt = interval_cnt + 16'd1;
                end
            end
            RD_EDGE:   state_nxt = WAIT_EDGE;
            WAIT_EDGE: state_nxt = (avm_readdata[7:0] == 8'h00) ? IDLE : RD_DATA;
            RD_DATA:   state_nxt = WAIT_DATA;
            WAIT_DATA: state_nxt = CLR;
            CLR:       state_nxt = PUSH;
            PUSH:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase

        addr_nxt    = PIO_ADDR_DATA;
        cs_nxt      = 1'b0;
        write_n_nxt = 1'b1;
        wdata_nxt   = '0;
        case (state_nxt)
            RD_EDGE: begin
                addr_nxt = PIO_ADDR_EDGE;
                cs_nxt   = 1'b1;
            end
            RD_DATA: begin
                cs_nxt = 1'b1;
            end
            CLR: begin
                addr_nxt    = PIO_ADDR_EDGE;
                cs_nxt      = 1'b1;
                write_n_nxt = 1'b0;
                wdata_nxt   = PIO_CLEAR_ALL;
            end
            default: ;
        endcase
    end

    // State register with registered bus and busy outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            interval_cnt   <= '0;
            avm_address    <= PIO_ADDR_DATA;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            interval_cnt   <= interval_nxt;
            avm_address    <= addr_nxt;
            avm_chipselect <= cs_nxt;
            avm_write_n    <= write_n_nxt;
            avm_writedata  <= wdata_nxt;
            busy           <= (state_nxt != IDLE);
        end
    end

    // Capture read data one cycle after each read strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
            data_q <= '0;
        end else begin
            if (state == WAIT_EDGE) mask_q <= avm_readdata[7:0];
            if (state == WAIT_DATA) data_q <= avm_readdata[7:0];
        end
    end

`ifdef PIO_POLL_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_q;

    // Free-running cycle counter, sampled when the poll starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
            if (state == RD_EDGE) ts_q <= ts_cnt;
        end
    end

    assign evt_timestamp = head_rec.timestamp;
`endif

    // Assemble the record to queue
    always_comb begin
        push_rec      = '0;
        push_rec.mask = mask_q;
        push_rec.data = data_q;
`ifdef PIO_POLL_TIMESTAMP_EN
        push_rec.timestamp = ts_q;
`endif
    end

    assign fifo_push = (state == PUSH);
    assign fifo_pop  = evt_valid && evt_ready;
    assign drop      = fifo_push && fifo_full && !fifo_pop;

    pio_evt_fifo #(
        .WIDTH ($bits(evt_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (push_rec),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (head_rec),
        .empty     (fifo_empty)
    );

    assign evt_valid = !fifo_empty;
    assign evt_mask  = head_rec.mask;
    assign evt_data  = head_rec.data;

    // Saturating count of records dropped on a full FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count <= '0;
        end else if (drop && (overflow_count != 8'hFF)) begin
            overflow_count <= overflow_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pio_edge_poller.sv
// Testbench for pio_edge_poller with a behavioural edge-capturing PIO slave.
// Timestamp checks are compiled in when PIO_POLL_TIMESTAMP_EN is defined.
module tb_pio_edge_poller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        evt_ready = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        evt_valid;
    logic [7:0]  evt_mask;
    logic [7:0]  evt_data;
`ifdef PIO_POLL_TIMESTAMP_EN
    logic [15:0] evt_timestamp;
`endif
    logic [7:0]  overflow_count;
    logic        busy;

    pio_edge_poller #(
        .POLL_INTERVAL (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_mask       (evt_mask),
        .evt_data       (evt_data),
`ifdef PIO_POLL_TIMESTAMP_EN
        .evt_timestamp  (evt_timestamp),
`endif
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // PIO slave model: rising-edge capture, 1-cycle registered reads,
    // upper read bits deliberately non-zero
    logic [7:0]  pio_in = 8'h00;
    logic [7:0]  pio_prev = 8'h00;
    logic [7:0]  pio_cap = 8'h00;
    logic [31:0] rd_q = 32'h0;
    int          cyc = 0;
    int          last_edge_cyc = 0;
    int          evt_edge_cyc = 0;

    assign avm_readdata = rd_q;

    always @(posedge clk) begin
        logic [7:0] clr;
        clr = (avm_chipselect && !avm_write_n && avm_address == 2'd3) ? avm_writedata[7:0] : 8'h00;
        pio_prev <= pio_in;
        pio_cap  <= (pio_cap | (pio_in & ~pio_prev)) & ~clr;
        if (avm_chipselect && avm_write_n && avm_address == 2'd3)
            rd_q <= {24'hA5A5A5, pio_cap};
        else if (avm_chipselect && avm_write_n && avm_address == 2'd0)
            rd_q <= {24'h5A5A5A, pio_in};
        else
            rd_q <= 32'h0;
        cyc <= cyc + 1;
        if (avm_chipselect && avm_write_n && avm_address == 2'd3) last_edge_cyc <= cyc;
        if (avm_chipselect && avm_write_n && avm_address == 2'd0) evt_edge_cyc <= last_edge_cyc;
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) bound_fail("wait_idle");
    endtask

    task automatic wait_rd_edge();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (avm_chipselect && avm_write_n && avm_address == 2'd3) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) bound_fail("wait_rd_edge");
    endtask

    task automatic wait_rd_data();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (avm_chipselect && avm_write_n && avm_address == 2'd0) ok = 1'b1;
        end
        if (!ok) bound_fail("wait_rd_data");
    endtask

    task automatic wait_clr();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (avm_chipselect && !avm_write_n) ok = 1'b1;
        end
        if (!ok) bound_fail("wait_clr");
    endtask

    task automatic wait_valid(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (evt_valid) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) bound_fail("wait_valid");
    endtask

    // Drive a new PIO level and return at the negedge of the PUSH cycle
    task automatic raise_evt(input logic [7:0] lvl);
        pio_in = lvl;
        wait_clr();
        @(negedge clk);
    endtask

    task automatic drain_one(input string name, input logic [7:0] m, input logic [7:0] d);
        check({name, "_valid"}, 32'(evt_valid), 32'd1);
        check({name, "_mask"}, 32'(evt_mask), 32'(m));
        check({name, "_data"}, 32'(evt_data), 32'(d));
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] pio;
        logic       evt;
        logic [7:0] mask;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_cs, exp_wn, exp_busy, exp_valid;
        logic [1:0]  exp_addr;
        logic [31:0] exp_wd;
`ifdef PIO_POLL_TIMESTAMP_EN
        logic [15:0] ts1, ts2;
        int c1, c2;
`endif

        vecs[0] = '{8'h3C, 1'b1, 8'h3C, 8'h3C};
        vecs[1] = '{8'h3D, 1'b1, 8'h01, 8'h3D};
        vecs[2] = '{8'h0D, 1'b0, 8'h00, 8'h00};
        vecs[3] = '{8'hF2, 1'b1, 8'hF2, 8'hF2};
        vecs[4] = '{8'h00, 1'b0, 8'h00, 8'h00};
        vecs[5] = '{8'h80, 1'b1, 8'h80, 8'h80};
        vecs[6] = '{8'hFF, 1'b1, 8'h7F, 8'hFF};
        vecs[7] = '{8'hFE, 1'b0, 8'h00, 8'h00};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_write_n", 32'(avm_write_n), 32'd1);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_wdata", avm_writedata, 32'd0);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_ovf", 32'(overflow_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        // Empty polls: 2 busy cycles out of every 6, read of address 3 only
        enable = 1'b1;
        wait_rd_edge();
        for (int k = 0; k < 18; k++) begin
            check($sformatf("idle_cs_k%0d", k), 32'(avm_chipselect), 32'((k % 6) == 0));
            check($sformatf("idle_addr_k%0d", k), 32'(avm_address), ((k % 6) == 0) ? 32'd3 : 32'd0);
            check($sformatf("idle_wn_k%0d", k), 32'(avm_write_n), 32'd1);
            check($sformatf("idle_busy_k%0d", k), 32'(busy), 32'((k % 6) < 2));
            @(negedge clk);
        end
        check("idle_no_evt", 32'(evt_valid), 32'd0);

        // Single event, cycle by cycle from the empty poll at k=0
        wait_rd_edge();
        @(negedge clk);
        pio_in = 8'h05;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            exp_cs    = (k == 6) || (k == 8) || (k == 10);
            exp_addr  = ((k == 6) || (k == 10)) ? 2'd3 : 2'd0;
            exp_wn    = (k != 10);
            exp_wd    = (k == 10) ? 32'hFFFF_FFFF : 32'h0;
            exp_busy  = (k >= 6) && (k <= 11);
            exp_valid = (k >= 12);
            check($sformatf("evt_cs_k%0d", k), 32'(avm_chipselect), 32'(exp_cs));
            check($sformatf("evt_addr_k%0d", k), 32'(avm_address), 32'(exp_addr));
            check($sformatf("evt_wn_k%0d", k), 32'(avm_write_n), 32'(exp_wn));
            check($sformatf("evt_wd_k%0d", k), avm_writedata, exp_wd);
            check($sformatf("evt_busy_k%0d", k), 32'(busy), 32'(exp_busy));
            check($sformatf("evt_valid_k%0d", k), 32'(evt_valid), 32'(exp_valid));
        end
        drain_one("evt05", 8'h05, 8'h05);
        check("evt05_popped", 32'(evt_valid), 32'd0);
        check("evt05_pio_cleared", 32'(pio_cap), 32'd0);
        enable = 1'b0;
        wait_idle();
        pio_in = 8'h00;

        // Table of level changes applied while the poller is parked
        for (int i = 0; i < 8; i++) begin
            enable = 1'b0;
            wait_idle();
            pio_in = vecs[i].pio;
            repeat (2) @(negedge clk);
            enable = 1'b1;
            if (vecs[i].evt) begin
                wait_valid(30);
                drain_one($sformatf("vec%0d", i), vecs[i].mask, vecs[i].data);
                check($sformatf("vec%0d_popped", i), 32'(evt_valid), 32'd0);
            end else begin
                repeat (20) @(negedge clk);
                check($sformatf("vec%0d_no_evt", i), 32'(evt_valid), 32'd0);
            end
        end

        // Six events with the consumer stalled: four held, two dropped
        enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        for (int i = 0; i < 6; i++) raise_evt(8'((2 << i) - 1));
        repeat (2) @(negedge clk);
        check("ovf_after_6", 32'(overflow_count), 32'd2);
        check("full_head_valid", 32'(evt_valid), 32'd1);
        check("full_head_mask", 32'(evt_mask), 32'h01);

        // Push into a full FIFO while the consumer pops in the same cycle
        pio_in = 8'h7F;
        wait_clr();
        @(negedge clk);
        check("push_cycle_busy", 32'(busy), 32'd1);
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        check("ovf_push_pop", 32'(overflow_count), 32'd2);
        drain_one("drain0", 8'h02, 8'h03);
        drain_one("drain1", 8'h04, 8'h07);
        drain_one("drain2", 8'h08, 8'h0F);
        drain_one("drain3", 8'h40, 8'h7F);
        check("drained_empty", 32'(evt_valid), 32'd0);

        // Overflow counter saturation
        for (int j = 0; j < 262; j++) begin
            pio_in = 8'h00;
            @(negedge clk);
            raise_evt(8'h40);
        end
        check("ovf_saturated", 32'(overflow_count), 32'd255);
        check("ovf_sat_valid", 32'(evt_valid), 32'd1);

        // Reset in WAIT_DATA: no clear issued, capture reported on next poll
        pio_in = 8'h41;
        wait_rd_data();
        @(negedge clk);
        check("wait_data_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        check("mid_rst_wn", 32'(avm_write_n), 32'd1);
        check("mid_rst_addr", 32'(avm_address), 32'd0);
        check("mid_rst_wd", avm_writedata, 32'd0);
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("mid_rst_cap_kept", 32'(pio_cap), 32'h01);
        reset_n = 1'b1;
        wait_valid(30);
        drain_one("post_rst", 8'h01, 8'h41);
        check("post_rst_cap_clr", 32'(pio_cap), 32'h00);

`ifdef PIO_POLL_TIMESTAMP_EN
        // Timestamp spacing equals the distance between the two RD_EDGE cycles
        raise_evt(8'h45);
        c1 = evt_edge_cyc;
        repeat (100) @(negedge clk);
        raise_evt(8'h4D);
        c2 = evt_edge_cyc;
        ts1 = evt_timestamp;
        drain_one("ts_evt1", 8'h04, 8'h45);
        ts2 = evt_timestamp;
        drain_one("ts_evt2", 8'h08, 8'h4D);
        check("ts_delta", 32'(ts2 - ts1), 32'(16'(c2 - c1)));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
